// File: rtl/serial_prog_loader_if.sv
// -----------------------------------------------------------------------------
// serial_prog_loader_if
//   Write port of the instruction SRAM pair as seen by the boot loader.
//
//   Signals:
//     instr_we_n   active-low write strobe, low for one cycle per word
//     instr_addr   word address (ADDR_W bits), valid while instr_we_n is low
//     instr_wdata  16-bit instruction word, valid while instr_we_n is low
//
//   Modports:
//     master  the loader, drives the write port
//     slave   the instruction memory, receives the write port
// -----------------------------------------------------------------------------
interface serial_prog_loader_if #(
    parameter int ADDR_W = 13
);
    logic              instr_we_n;
    logic [ADDR_W-1:0] instr_addr;
    logic [15:0]       instr_wdata;

    modport master (
        output instr_we_n,
        output instr_addr,
        output instr_wdata
    );

    modport slave (
        input instr_we_n,
        input instr_addr,
        input instr_wdata
    );
endinterface

// File: rtl/serial_prog_loader.sv
// -----------------------------------------------------------------------------
// serial_prog_loader
//   Boot-time program loader. Receives a framed byte stream on a UART line
//   (8N1, LSB first), assembles 16-bit words and writes them to sequential
//   instruction addresses. The processor is held in reset while loading and
//   released with a one-cycle start pulse when the frame completes.
//
//   Frame: CNT_LO, CNT_HI, N x (word LO, word HI) [, checksum byte]
//
//   Build option:
//     SERIAL_PROG_LOADER_CKSUM_EN  when defined, a checksum byte follows the
//                                  payload; the 8-bit sum of every frame byte
//                                  including the checksum must be 0x00.
//
//   Ports:
//     clk           system clock, rising edge
//     reset         asynchronous active-low reset
//     load_en       level, arms the loader; low aborts to IDLE
//     err_clr       pulse, clears the sticky error and returns to IDLE
//     rx            asynchronous UART line, idles high
//     instr_bus     instruction SRAM write port (master modport)
//     cpu_hold      1 holds the processor in reset
//     start         one-cycle pulse when a load completes
//     busy          1 while a load is in progress
//     err           sticky error: bit0 frame error, bit1 count/checksum error
//     words_loaded  number of words written in the current load
// -----------------------------------------------------------------------------
module serial_prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 13,
    parameter int MAX_WORDS    = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic                 err_clr,
    input  logic                 rx,
    serial_prog_loader_if.master instr_bus,
    output logic                 cpu_hold,
    output logic                 start,
    output logic                 busy,
    output logic [1:0]           err,
    output logic [ADDR_W-1:0]    words_loaded
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]      MAX_N     = 16'(MAX_WORDS);

    // -------------------------------------------------------------------------
    // UART receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_reg, rx_state_next;
    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CNT_W-1:0] tick_reg, tick_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             rx_valid;
    logic             frame_err;
    logic [7:0]       rx_byte;

    assign rx_byte = shift_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            tick_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            tick_reg     <= tick_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        tick_next     = tick_reg + 1'b1;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        rx_valid      = 1'b0;
        frame_err     = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                tick_next = '0;
                // Only a 1->0 transition starts a byte, so a line stuck low
                // after a bad stop bit does not retrigger the receiver.
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (tick_reg == HALF_LAST) begin
                    tick_next     = '0;
                    bit_next      = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_reg == BIT_LAST) begin
                    tick_next  = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick_reg == BIT_LAST) begin
                    tick_next     = '0;
                    rx_valid      = rx_sync_reg;
                    frame_err     = !rx_sync_reg;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame / load FSM
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE, CNT_HI, W_LO, W_HI, WRITE, DONE, ERR
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
        , CKSUM
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        cnt_lo_reg, cnt_lo_next;
    logic [15:0]       count_reg, count_next;
    logic [15:0]       word_reg, word_next;
    logic [ADDR_W-1:0] words_loaded_reg, words_loaded_next;
    logic [1:0]        err_reg, err_next;
    logic              start_reg, start_next;
    logic [15:0]       new_count;
    logic [ADDR_W-1:0] wl_inc;
    logic              accepting;
    state_t            end_state;

`ifdef SERIAL_PROG_LOADER_CKSUM_EN
    logic [7:0] cksum_reg, cksum_next;
    logic [7:0] cksum_sum;
    assign cksum_sum = cksum_reg + rx_byte;
    assign end_state = CKSUM;
`else
    assign end_state = DONE;
`endif

    assign new_count = {rx_byte, cnt_lo_reg};
    assign wl_inc    = words_loaded_reg + 1'b1;
    // States in which received bytes belong to the frame being loaded.
    assign accepting = (state_reg != DONE) && (state_reg != ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cnt_lo_reg       <= '0;
            count_reg        <= '0;
            word_reg         <= '0;
            words_loaded_reg <= '0;
            err_reg          <= '0;
            start_reg        <= 1'b0;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
            cksum_reg        <= '0;
`endif
        end else begin
            state_reg        <= state_next;
            cnt_lo_reg       <= cnt_lo_next;
            count_reg        <= count_next;
            word_reg         <= word_next;
            words_loaded_reg <= words_loaded_next;
            err_reg          <= err_next;
            start_reg        <= start_next;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
            cksum_reg        <= cksum_next;
`endif
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_lo_next       = cnt_lo_reg;
        count_next        = count_reg;
        word_next         = word_reg;
        words_loaded_next = words_loaded_reg;
        err_next          = err_reg;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
        cksum_next        = cksum_reg;
`endif
        if (!load_en && state_reg != ERR) begin
            // Abort (or leave DONE): error flags are left untouched.
            state_next = IDLE;
        end else if (frame_err && accepting) begin
            // A frame error beats a simultaneous err_clr.
            state_next  = ERR;
            err_next[0] = 1'b1;
        end else if (err_clr && state_reg != DONE) begin
            state_next = IDLE;
            err_next   = '0;
        end else begin
            case (state_reg)
                IDLE: if (rx_valid) begin
                    cnt_lo_next = rx_byte;
                    state_next  = CNT_HI;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
                    cksum_next  = rx_byte;
`endif
                end
                CNT_HI: if (rx_valid) begin
                    count_next = new_count;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
                    cksum_next = cksum_sum;
`endif
                    if (new_count == 16'd0) begin
                        state_next = end_state;
                    end else if (new_count > MAX_N) begin
                        err_next[1] = 1'b1;
                        state_next  = ERR;
                    end else begin
                        state_next = W_LO;
                    end
                end
                W_LO: if (rx_valid) begin
                    word_next[7:0] = rx_byte;
                    state_next     = W_HI;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
                    cksum_next     = cksum_sum;
`endif
                end
                W_HI: if (rx_valid) begin
                    word_next[15:8] = rx_byte;
                    state_next      = WRITE;
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
                    cksum_next      = cksum_sum;
`endif
                end
                WRITE: begin
                    words_loaded_next = wl_inc;
                    state_next = (16'(wl_inc) == count_reg) ? end_state : W_LO;
                end
`ifdef SERIAL_PROG_LOADER_CKSUM_EN
                CKSUM: if (rx_valid) begin
                    if (cksum_sum == 8'h00) begin
                        state_next = DONE;
                    end else begin
                        err_next[1] = 1'b1;
                        state_next  = ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
        // The word counter always restarts from zero in IDLE.
        if (state_next == IDLE) begin
            words_loaded_next = '0;
        end
    end

    // Start is high for exactly the first cycle spent in DONE.
    assign start_next = (state_next == DONE) && (state_reg != DONE);

    assign instr_bus.instr_we_n  = (state_reg != WRITE);
    assign instr_bus.instr_addr  = words_loaded_reg;
    assign instr_bus.instr_wdata = word_reg;

    assign cpu_hold     = (state_reg != DONE);
    assign start        = start_reg;
    assign busy         = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR);
    assign err          = err_reg;
    assign words_loaded = words_loaded_reg;

endmodule
